// File: rtl/divmod31_seq_if.sv
// Handshake bundle for the sequential mod-31 divider.
// master drives start/a/b; slave returns busy/done/y/div_err.
interface divmod31_seq_if;
    logic       start;
    logic [4:0] a;
    logic [4:0] b;
    logic       busy;
    logic       done;
    logic [4:0] y;
    logic       div_err;

    modport master (
        output start, a, b,
        input  busy, done, y, div_err
    );

    modport slave (
        input  start, a, b,
        output busy, done, y, div_err
    );
endinterface

// File: rtl/divmod31_seq.sv
// Sequential mod-31 divider: y = a * b^29 (mod 31) by square-and-multiply.
// Ports: clk, rst_n (async low), bus (start/a/b in, busy/done/y/div_err out).
module divmod31_seq #(
    parameter bit HOLD_RESULT = 1'b1,
    parameter bit ZERO_FAST   = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    divmod31_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EXP, FIN, DONE} state_t;

    state_t     state_q, state_d;
    logic [4:0] r_q, r_d;
    logic [4:0] a_q, a_d;
    logic [4:0] b_q, b_d;
    logic [2:0] step_q, step_d;
    logic [4:0] y_q, y_d;
    logic       err_q, err_d;

    // Fold the high 5 bits back in (2^5 == 1 mod 31), then one
    // conditional subtract; 31 itself is the alias of 0.
    function automatic logic [4:0] mul31(input logic [4:0] x,
                                         input logic [4:0] z);
        logic [9:0] m;
        logic [5:0] s;
        m = x * z;
        s = {1'b0, m[9:5]} + {1'b0, m[4:0]};
        if (s >= 6'd31) s = s - 6'd31;
        if (s == 6'd31) s = 6'd0;
        return s[4:0];
    endfunction

    function automatic logic [4:0] canon(input logic [4:0] v);
        return (v == 5'd31) ? 5'd0 : v;
    endfunction

    logic [4:0] a_can;
    logic [4:0] b_can;
    logic       is_mul;

    assign a_can = canon(bus.a);
    assign b_can = canon(bus.b);

    // Exponent bits after the leading one: SQ,MUL,SQ,MUL,SQ,SQ,MUL.
    assign is_mul = (step_q == 3'd1) || (step_q == 3'd3) ||
                    (step_q == 3'd6);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        a_d     = a_q;
        b_d     = b_q;
        step_d  = step_q;
        y_d     = y_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d    = a_can;
                    b_d    = b_can;
                    r_d    = b_can;
                    step_d = 3'd0;
                    y_d    = 5'd0;
                    err_d  = 1'b0;
                    // Zero divisor skips the exponent and lands in FIN,
                    // where the error flag is raised with y=0.
                    if (ZERO_FAST && (b_can == 5'd0)) state_d = FIN;
                    else                              state_d = EXP;
                end
            end
            EXP: begin
                r_d    = mul31(r_q, is_mul ? b_q : r_q);
                step_d = step_q + 3'd1;
                if (step_q == 3'd6) state_d = FIN;
            end
            FIN: begin
                y_d     = (b_q == 5'd0) ? 5'd0 : mul31(r_q, a_q);
                err_d   = (b_q == 5'd0);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                if (!HOLD_RESULT) begin
                    y_d   = 5'd0;
                    err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= 5'd0;
            a_q     <= 5'd0;
            b_q     <= 5'd0;
            step_q  <= 3'd0;
            y_q     <= 5'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            a_q     <= a_d;
            b_q     <= b_d;
            step_q  <= step_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy    = (state_q == EXP) || (state_q == FIN);
    assign bus.done    = (state_q == DONE);
    assign bus.y       = y_q;
    assign bus.div_err = err_q;

endmodule
